// File: rtl/seg7_leitor.sv
// Seven-segment pattern reader: it waits until a pattern has been stable for
// STABLE_CYCLES samples, then decodes it into a 5-bit code or flags it as blank or illegal.
module seg7_leitor #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       enable,
  input  logic [6:0] display,
  output logic [4:0] estado,
  output logic       valido,
  output logic       travado,
  output logic       erro,
  output logic       apagado,
  output logic [1:0] fsm_state
);

  localparam logic [1:0] VAZIO   = 2'd0;
  localparam logic [1:0] ESTAB   = 2'd1;
  localparam logic [1:0] TRAVADO = 2'd2;

  localparam logic [3:0] STABLE = 4'(STABLE_CYCLES);

  logic [1:0] state;
  logic [6:0] amostra;
  logic [3:0] cnt;
  logic [3:0] cnt_inc;
  logic       hit;
  logic       blank;
  logic [4:0] code;

  assign cnt_inc   = cnt + 4'd1;
  assign blank     = (amostra == 7'b1111111);
  assign fsm_state = state;

  // Active-low patterns, bit 6 = segment g.
  always_comb begin
    hit  = 1'b1;
    code = 5'h00;
    case (amostra)
      7'b1000000: code = 5'h00;
      7'b1111001: code = 5'h01;
      7'b0100100: code = 5'h02;
      7'b0110000: code = 5'h03;
      7'b0011001: code = 5'h04;
      7'b0010010: code = 5'h05;
      7'b0000010: code = 5'h06;
      7'b1111000: code = 5'h07;
      7'b0000000: code = 5'h08;
      7'b0010000: code = 5'h09;
      7'b0001000: code = 5'h0A;
      7'b0000011: code = 5'h0B;
      7'b1000110: code = 5'h0C;
      7'b0100001: code = 5'h0D;
      7'b0000110: code = 5'h0E;
      7'b0001110: code = 5'h0F;
      7'b1111110: code = 5'h10;
      7'b1111101: code = 5'h11;
      7'b1111011: code = 5'h12;
      7'b1110111: code = 5'h13;
      7'b1101111: code = 5'h14;
      7'b1011111: code = 5'h15;
      7'b0111111: code = 5'h16;
      7'b1111100: code = 5'h17;
      7'b1110011: code = 5'h18;
      7'b1100111: code = 5'h19;
      7'b1001111: code = 5'h1A;
      7'b0011111: code = 5'h1B;
      7'b1110001: code = 5'h1C;
      7'b1100011: code = 5'h1D;
      7'b1000111: code = 5'h1E;
      7'b0001111: code = 5'h1F;
      default:    hit  = 1'b0;
    endcase
  end

  // valido is a single-cycle strobe on the accepting edge; there is no
  // back-pressure, so a consumer must capture estado on that same cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= VAZIO;
      amostra <= 7'b1111111;
      cnt     <= 4'd0;
      estado  <= 5'h00;
      valido  <= 1'b0;
      travado <= 1'b0;
      erro    <= 1'b0;
      apagado <= 1'b0;
    end else begin
      valido <= 1'b0;
      if (enable) begin
        // An unknown state encoding is handled like VAZIO so it recovers.
        if ((state != ESTAB && state != TRAVADO) || display != amostra) begin
          amostra <= display;
          cnt     <= 4'd1;
          state   <= ESTAB;
          travado <= 1'b0;
        end else if (state == ESTAB) begin
          cnt <= cnt_inc;
          if (cnt_inc == STABLE) begin
            state   <= TRAVADO;
            travado <= 1'b1;
            valido  <= hit;
            if (hit) begin
              estado  <= code;
              erro    <= 1'b0;
              apagado <= 1'b0;
            end else begin
              erro    <= !blank;
              apagado <= blank;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_seg7_leitor.sv
// Bench for seg7_leitor: directed vector table, hand-written corner sequences,
// and randomized stimulus against a run-length reference model.
module tb_seg7_leitor;

  localparam int S = 4;

  logic       clock;
  logic       reset_n;
  logic       enable;
  logic [6:0] display;
  logic [4:0] estado;
  logic       valido;
  logic       travado;
  logic       erro;
  logic       apagado;
  logic [1:0] fsm_state;

  int checks   = 0;
  int failures = 0;

  logic [6:0] pat [32];
  logic [4:0] exp_q [$];

  // reference model state
  bit         m_first;
  logic [6:0] m_last;
  int         m_run;
  logic [4:0] m_estado;
  logic       m_valido, m_travado, m_erro, m_apagado;

  seg7_leitor #(.STABLE_CYCLES(S)) dut (
    .clock(clock), .reset_n(reset_n), .enable(enable), .display(display),
    .estado(estado), .valido(valido), .travado(travado), .erro(erro),
    .apagado(apagado), .fsm_state(fsm_state)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int lookup(input logic [6:0] d);
    for (int i = 0; i < 32; i++)
      if (pat[i] == d) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_first = 1'b1; m_last = 7'b1111111; m_run = 0;
    m_estado = 5'h00; m_valido = 1'b0; m_travado = 1'b0;
    m_erro = 1'b0; m_apagado = 1'b0;
  endtask

  // Acceptance happens when the run of identical enabled samples reaches S.
  task automatic model_edge(input logic en, input logic [6:0] d);
    int idx;
    m_valido = 1'b0;
    if (!en) return;
    if (m_first || d != m_last) begin
      m_first = 1'b0; m_last = d; m_run = 1; m_travado = 1'b0;
    end else if (m_run < S) begin
      m_run++;
      if (m_run == S) begin
        m_travado = 1'b1;
        idx = lookup(d);
        if (idx >= 0) begin
          m_estado = 5'(idx); m_erro = 1'b0; m_apagado = 1'b0; m_valido = 1'b1;
        end else if (d == 7'b1111111) begin
          m_erro = 1'b0; m_apagado = 1'b1;
        end else begin
          m_erro = 1'b1; m_apagado = 1'b0;
        end
      end
    end
  endtask

  task automatic compare_model(input string tag);
    check({tag, ".valido"},  valido,  m_valido);
    check({tag, ".estado"},  estado,  m_estado);
    check({tag, ".travado"}, travado, m_travado);
    check({tag, ".erro"},    erro,    m_erro);
    check({tag, ".apagado"}, apagado, m_apagado);
    check({tag, ".state_locked"}, fsm_state == 2'd2, m_travado);
  endtask

  // driver: inputs are already set; advance one edge and sample 1 time unit later
  task automatic tick(input bit chk, input string tag);
    @(posedge clock);
    #1;
    model_edge(enable, display);
    if (chk) compare_model(tag);
  endtask

  task automatic apply_reset(input string tag);
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    check({tag, ".rst_estado"},  estado,    5'h00);
    check({tag, ".rst_valido"},  valido,    1'b0);
    check({tag, ".rst_travado"}, travado,   1'b0);
    check({tag, ".rst_erro"},    erro,      1'b0);
    check({tag, ".rst_apagado"}, apagado,   1'b0);
    check({tag, ".rst_state"},   fsm_state, 2'd0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  typedef struct {
    logic       en;
    logic [6:0] d;
    logic       v;
    logic [4:0] e;
    logic       t;
    logic       er;
    logic       ap;
  } vec_t;

  vec_t vecs [21];

  initial begin
    int n_valid;
    int kind, len, idx;
    logic [6:0] d;

    pat = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
            7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
            7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
            7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110,
            7'b1111110, 7'b1111101, 7'b1111011, 7'b1110111,
            7'b1101111, 7'b1011111, 7'b0111111, 7'b1111100,
            7'b1110011, 7'b1100111, 7'b1001111, 7'b0011111,
            7'b1110001, 7'b1100011, 7'b1000111, 7'b0001111};

    // en, display, valido, estado, travado, erro, apagado
    vecs[0]  = '{1'b1, 7'b0100100, 1'b0, 5'h00, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 7'b0100100, 1'b0, 5'h00, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 7'b0100100, 1'b0, 5'h00, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 7'b0100100, 1'b1, 5'h02, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 7'b0100100, 1'b0, 5'h02, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 7'b0000110, 1'b0, 5'h02, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 7'b0000110, 1'b0, 5'h02, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 7'b0001110, 1'b0, 5'h02, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 7'b0001110, 1'b0, 5'h02, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 7'b0001110, 1'b0, 5'h02, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 7'b0001110, 1'b1, 5'h0F, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 7'b1010101, 1'b0, 5'h0F, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 7'b1010101, 1'b0, 5'h0F, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{1'b1, 7'b1010101, 1'b0, 5'h0F, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{1'b1, 7'b1010101, 1'b0, 5'h0F, 1'b1, 1'b1, 1'b0};
    vecs[15] = '{1'b1, 7'b1111111, 1'b0, 5'h0F, 1'b0, 1'b1, 1'b0};
    vecs[16] = '{1'b1, 7'b1111111, 1'b0, 5'h0F, 1'b0, 1'b1, 1'b0};
    vecs[17] = '{1'b1, 7'b1111111, 1'b0, 5'h0F, 1'b0, 1'b1, 1'b0};
    vecs[18] = '{1'b1, 7'b1111111, 1'b0, 5'h0F, 1'b1, 1'b0, 1'b1};
    vecs[19] = '{1'b0, 7'b0100100, 1'b0, 5'h0F, 1'b1, 1'b0, 1'b1};
    vecs[20] = '{1'b1, 7'b0100100, 1'b0, 5'h0F, 1'b0, 1'b0, 1'b1};

    reset_n = 1'b1;
    enable  = 1'b0;
    display = 7'b1111111;
    model_reset();
    #3;
    apply_reset("init");

    // directed vector table
    for (int i = 0; i < 21; i++) begin
      enable  = vecs[i].en;
      display = vecs[i].d;
      tick(1'b0, "vec");
      check($sformatf("vec%0d.valido", i),  valido,  vecs[i].v);
      check($sformatf("vec%0d.estado", i),  estado,  vecs[i].e);
      check($sformatf("vec%0d.travado", i), travado, vecs[i].t);
      check($sformatf("vec%0d.erro", i),    erro,    vecs[i].er);
      check($sformatf("vec%0d.apagado", i), apagado, vecs[i].ap);
    end

    // sweep of every table pattern plus blank, scoreboard on valido
    apply_reset("sweep");
    enable  = 1'b1;
    n_valid = 0;
    for (int p = 0; p < 33; p++) begin
      display = (p < 32) ? pat[p] : 7'b1111111;
      if (p < 32) exp_q.push_back(5'(p));
      for (int k = 0; k < 5; k++) begin
        tick(1'b1, "sweep");
        if (valido === 1'b1) begin
          n_valid++;
          if (exp_q.size() == 0) check("sweep.extra_valido", 1'b1, 1'b0);
          else check("sweep.code", estado, exp_q.pop_front());
        end
      end
      if (p == 32) check("sweep.blank_apagado", apagado, 1'b1);
    end
    check("sweep.valido_count", n_valid, 32);
    check("sweep.queue_empty", exp_q.size(), 0);

    // enable pause mid-count
    apply_reset("pause");
    enable  = 1'b1;
    display = 7'b1111001;
    tick(1'b1, "pause.e1");
    tick(1'b1, "pause.e2");
    enable = 1'b0;
    for (int k = 0; k < 3; k++) tick(1'b1, "pause.off");
    enable = 1'b1;
    tick(1'b1, "pause.r1");
    check("pause.no_early", valido, 1'b0);
    tick(1'b1, "pause.r2");
    check("pause.accept", valido, 1'b1);
    check("pause.code", estado, 5'h01);

    // reset at edge 3 of a count
    apply_reset("midcnt");
    enable  = 1'b1;
    display = 7'b0000000;
    for (int k = 0; k < 3; k++) tick(1'b1, "midcnt.pre");
    apply_reset("midcnt.abort");
    for (int k = 0; k < 3; k++) begin
      tick(1'b1, "midcnt.post");
      check("midcnt.no_valido", valido, 1'b0);
    end
    tick(1'b1, "midcnt.post4");
    check("midcnt.valido_4th", valido, 1'b1);
    check("midcnt.code", estado, 5'h08);

    // reset during a valido pulse
    display = 7'b0010000;
    for (int k = 0; k < S; k++) tick(1'b1, "pulse");
    check("pulse.seen", valido, 1'b1);
    apply_reset("pulse.abort");

    // randomized segments against the model, with occasional resets
    enable = 1'b1;
    for (int s = 0; s < 300; s++) begin
      kind = $urandom_range(0, 9);
      if (kind < 6) begin
        idx = $urandom_range(0, 31);
        d = pat[idx];
      end else if (kind < 8) begin
        d = 7'b1111111;
      end else begin
        d = 7'($urandom_range(0, 127));
      end
      display = d;
      len = $urandom_range(1, 6);
      for (int k = 0; k < len; k++) begin
        enable = ($urandom_range(0, 9) != 0);
        tick(1'b1, "rand");
      end
      if ($urandom_range(0, 39) == 0) apply_reset("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seg7_leitor.md
SEG7_LEITOR -- requirements
Module: seg7_leitor

Interface
REQ-001 Parameter STABLE_CYCLES, default 4, number of consecutive identical samples required to accept a pattern; legal range 2..15.
REQ-002 clock  input  1  sole clock, all state updates on rising edge.
REQ-003 reset_n  input  1  reset, asynchronous and active-low.
REQ-004 enable  input  1  sampling enable; 0 freezes all internal state and outputs except valido, which SHALL be 0.
REQ-005 display  input  7  active-low 7-segment pattern, bit 6 = segment g (leftmost bit), bit 0 = segment a.
REQ-006 estado  output  5  recovered 5-bit code of the last accepted pattern.
REQ-007 valido  output  1  one-cycle pulse, asserted on the edge a legal pattern is accepted.
REQ-008 travado  output  1  level, 1 while the current sampled pattern is accepted and unchanged.
REQ-009 erro  output  1  level, 1 when the accepted pattern is neither a table entry nor blank.
REQ-010 apagado  output  1  level, 1 when the accepted pattern is blank (1111111).

Function
REQ-011 Decode table (code:pattern) SHALL be exactly: 00:1000000 01:1111001 02:0100100 03:0110000 04:0011001 05:0010010 06:0000010 07:1111000 08:0000000 09:0010000 0A:0001000 0B:0000011 0C:1000110 0D:0100001 0E:0000110 0F:0001110.
REQ-012 Table continued: 10:1111110 11:1111101 12:1111011 13:1110111 14:1101111 15:1011111 16:0111111 17:1111100 18:1110011 19:1100111 1A:1001111 1B:0011111 1C:1110001 1D:1100011 1E:1000111 1F:0001111.
REQ-013 Internal registers: amostra (7 bits, last sampled pattern), cnt (4 bits, consecutive-sample count), FSM state.
REQ-014 FSM states: VAZIO (nothing sampled), ESTAB (counting stability), TRAVADO (pattern accepted).
REQ-015 With enable=1 and display != amostra, or state VAZIO: amostra <= display, cnt <= 1, state <= ESTAB, travado <= 0; estado, erro and apagado hold their previous values.
REQ-016 With enable=1, state ESTAB and display == amostra: cnt <= cnt+1; when the new value equals STABLE_CYCLES, state <= TRAVADO and acceptance occurs on that same edge.
REQ-017 Acceptance: travado <= 1 and erro, apagado and estado are loaded from the decode of amostra, with valido <= 1 only for a table entry.
REQ-018 Decode results: table entry -> estado=code, erro=0, apagado=0; blank -> estado unchanged, erro=0, apagado=1; any other pattern -> estado unchanged, erro=1, apagado=0.
REQ-019 In state TRAVADO with display == amostra: no change; cnt saturates at STABLE_CYCLES; valido=0 (no repeated pulse).
REQ-020 Latency: a pattern first present before sampling edge k is accepted on edge k+STABLE_CYCLES-1 if it is unchanged through that edge.
REQ-021 Any change of display before acceptance restarts counting per REQ-015; glitches shorter than STABLE_CYCLES samples never produce valido.
REQ-022 A change while TRAVADO drops travado on the next edge, and valido fires again only after the new pattern is accepted, including a return to the same code.
REQ-023 enable=0 mid-count pauses the count: cnt and amostra are held and counting resumes when enable returns to 1.

Reset
REQ-024 reset_n=0 SHALL immediately force state=VAZIO, amostra=1111111, cnt=0, estado=00000, valido=0, travado=0, erro=0, apagado=0.
REQ-025 Reset asserted mid-count or during a valido pulse aborts it, and no valido is produced for a pattern sampled before the reset.
REQ-026 After reset release, the first enabled edge is treated as a change per REQ-015.

Verification
REQ-027 STABLE_CYCLES=4, display=0100100 held from edge 1 -> on edge 4: valido pulses 1 cycle, estado=00010, travado=1, erro=0.
REQ-028 display=0000110 for 2 edges then 0001110 held -> no valido for 0E; on the 4th edge of 0001110: estado=01111, valido=1.
REQ-029 display=1010101 held 4 edges -> erro=1, valido=0, travado=1, estado keeps its prior value.
REQ-030 All 32 table patterns plus blank applied in sequence, each held 5 edges -> exactly 32 valido pulses with matching estado, and apagado=1 only for blank.
REQ-031 Pattern 1111001 held, enable=0 for 3 cycles after edge 2, then enable=1 -> acceptance on the 2nd enabled edge after resume, with estado=00001.
REQ-032 reset_n pulsed low at edge 3 of a 4-edge count -> all outputs at reset values immediately, and valido occurs only 4 enabled edges after release.
